// File: rtl/cnn_pkg.sv
// cnn_pkg: shared parameter defaults and the layer scheduler state encoding.
package cnn_pkg;

    localparam int ARRAY_SIZE_DEF    = 9;
    localparam int DIM_DATA_SIZE_DEF = 16;
    localparam int ADDR_WIDTH_DEF    = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_I,
        ST_COMPUTE,
        ST_NEXT,
        ST_FINISH
    } sched_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: per-layer tile counter, weight address accumulator and
// valid-filter count for the current tile of the convolution scheduler.
module tile_addr_gen
    import cnn_pkg::*;
#(
    parameter int ARRAY_SIZE    = ARRAY_SIZE_DEF,
    parameter int DIM_DATA_SIZE = DIM_DATA_SIZE_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_load,
    input  logic                     i_advance,
    input  logic [DIM_DATA_SIZE-1:0] i_number_filters,
    input  logic [ADDR_WIDTH-1:0]    i_initial_address,
    input  logic [ADDR_WIDTH-1:0]    i_tile_stride,
    output logic [DIM_DATA_SIZE-1:0] o_tile_index,
    output logic [ADDR_WIDTH-1:0]    o_wfc_address,
    output logic [DIM_DATA_SIZE-1:0] o_active_filters,
    output logic                     o_more_tiles
);

    localparam logic [DIM_DATA_SIZE-1:0] LP_ARRAY = DIM_DATA_SIZE'(ARRAY_SIZE);

    logic [DIM_DATA_SIZE-1:0] r_tile_index;
    logic [DIM_DATA_SIZE-1:0] r_tile_count;
    logic [DIM_DATA_SIZE-1:0] r_remaining;
    logic [DIM_DATA_SIZE-1:0] r_active_filters;
    logic [ADDR_WIDTH-1:0]    r_wfc_address;
    logic [ADDR_WIDTH-1:0]    r_stride;

    logic [DIM_DATA_SIZE:0]   w_nf_round;
    logic [DIM_DATA_SIZE-1:0] w_tile_count;
    logic [DIM_DATA_SIZE-1:0] w_rem_next;

    // Tile count as ceil(filters / ARRAY_SIZE) and filters left after this tile
    always_comb begin
        w_nf_round   = {1'b0, i_number_filters} + (DIM_DATA_SIZE+1)'(ARRAY_SIZE - 1);
        w_tile_count = DIM_DATA_SIZE'(w_nf_round / (DIM_DATA_SIZE+1)'(ARRAY_SIZE));
        w_rem_next   = r_remaining - LP_ARRAY;
    end

    // Load layer geometry on start; step to the next tile on advance.
    // The address is accumulated by stride instead of multiplying index*stride;
    // the ADDR_WIDTH adder gives the same modulo-2^ADDR_WIDTH result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tile_index     <= '0;
            r_tile_count     <= '0;
            r_remaining      <= '0;
            r_active_filters <= '0;
            r_wfc_address    <= '0;
            r_stride         <= '0;
        end else if (i_load) begin
            r_tile_index     <= '0;
            r_tile_count     <= w_tile_count;
            r_remaining      <= i_number_filters;
            r_active_filters <= (i_number_filters < LP_ARRAY) ? i_number_filters : LP_ARRAY;
            r_wfc_address    <= i_initial_address;
            r_stride         <= i_tile_stride;
        end else if (i_advance) begin
            r_tile_index     <= r_tile_index + DIM_DATA_SIZE'(1);
            r_remaining      <= w_rem_next;
            r_active_filters <= (w_rem_next < LP_ARRAY) ? w_rem_next : LP_ARRAY;
            r_wfc_address    <= r_wfc_address + r_stride;
        end
    end

    assign o_tile_index     = r_tile_index;
    assign o_wfc_address    = r_wfc_address;
    assign o_active_filters = r_active_filters;
    assign o_more_tiles     = (r_tile_index + DIM_DATA_SIZE'(1)) < r_tile_count;

endmodule

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: sequences weight fill, input fill and compute for each
// ARRAY_SIZE-filter tile of one convolution layer.
// Optional: define SCHED_PERF_CNT_EN to add the 32-bit perf_cycles busy counter.
module conv_layer_scheduler
    import cnn_pkg::*;
#(
    parameter int ARRAY_SIZE    = ARRAY_SIZE_DEF,
    parameter int DIM_DATA_SIZE = DIM_DATA_SIZE_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIM_DATA_SIZE-1:0] weight_size,
    input  logic [DIM_DATA_SIZE-1:0] number_filters,
    input  logic [ADDR_WIDTH-1:0]    initial_address,
    input  logic [ADDR_WIDTH-1:0]    tile_stride,
    output logic                     wfc_start,
    output logic [ADDR_WIDTH-1:0]    wfc_address,
    input  logic                     wfc_done,
    output logic                     ifc_start,
    input  logic                     ifc_done,
    output logic                     cmp_start,
    input  logic                     cmp_done,
    output logic [DIM_DATA_SIZE-1:0] tile_index,
    output logic [DIM_DATA_SIZE-1:0] active_filters,
    output logic                     busy,
    output logic                     done
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]              perf_cycles
`endif
);

    sched_state_t r_state;
    logic         r_wfc_start;
    logic         r_ifc_start;
    logic         r_cmp_start;
    logic         r_busy;
    logic         r_done;

    logic         w_accept;
    logic         w_empty_layer;
    logic         w_advance;
    logic         w_more_tiles;

    assign w_accept      = (r_state == ST_IDLE) && start;
    assign w_empty_layer = (number_filters == '0) || (weight_size == '0);
    assign w_advance     = (r_state == ST_NEXT) && w_more_tiles;

    tile_addr_gen #(
        .ARRAY_SIZE    (ARRAY_SIZE),
        .DIM_DATA_SIZE (DIM_DATA_SIZE),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_tile_addr_gen (
        .clk               (clk),
        .reset             (reset),
        .i_load            (w_accept),
        .i_advance         (w_advance),
        .i_number_filters  (number_filters),
        .i_initial_address (initial_address),
        .i_tile_stride     (tile_stride),
        .o_tile_index      (tile_index),
        .o_wfc_address     (wfc_address),
        .o_active_filters  (active_filters),
        .o_more_tiles      (w_more_tiles)
    );

    // Layer FSM with registered start/busy/done outputs; starts are one-cycle pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_wfc_start <= 1'b0;
            r_ifc_start <= 1'b0;
            r_cmp_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wfc_start <= 1'b0;
            r_ifc_start <= 1'b0;
            r_cmp_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_empty_layer) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_LOAD_W;
                            r_wfc_start <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (wfc_done) begin
                        r_state     <= ST_LOAD_I;
                        r_ifc_start <= 1'b1;
                    end
                end
                ST_LOAD_I: begin
                    if (ifc_done) begin
                        r_state     <= ST_COMPUTE;
                        r_cmp_start <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (cmp_done) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (w_more_tiles) begin
                        r_state     <= ST_LOAD_W;
                        r_wfc_start <= 1'b1;
                    end else begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wfc_start = r_wfc_start;
    assign ifc_start = r_ifc_start;
    assign cmp_start = r_cmp_start;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_perf_cycles;

    // Busy-cycle counter: restarts on each accepted layer, saturates at all ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cycles <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
        end else if (r_busy && (r_perf_cycles != '1)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb_conv_layer_scheduler: directed and randomized layers against a tile-level
// reference model; the bench also acts as the three fill/compute sub-blocks.
module tb_conv_layer_scheduler;

    localparam int AS = 9;
    localparam int DW = 16;
    localparam int AW = 15;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] weight_size;
    logic [DW-1:0] number_filters;
    logic [AW-1:0] initial_address;
    logic [AW-1:0] tile_stride;
    logic          wfc_start;
    logic [AW-1:0] wfc_address;
    logic          wfc_done;
    logic          ifc_start;
    logic          ifc_done;
    logic          cmp_start;
    logic          cmp_done;
    logic [DW-1:0] tile_index;
    logic [DW-1:0] active_filters;
    logic          busy;
    logic          done;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    conv_layer_scheduler #(
        .ARRAY_SIZE    (AS),
        .DIM_DATA_SIZE (DW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .weight_size     (weight_size),
        .number_filters  (number_filters),
        .initial_address (initial_address),
        .tile_stride     (tile_stride),
        .wfc_start       (wfc_start),
        .wfc_address     (wfc_address),
        .wfc_done        (wfc_done),
        .ifc_start       (ifc_start),
        .ifc_done        (ifc_done),
        .cmp_start       (cmp_start),
        .cmp_done        (cmp_done),
        .tile_index      (tile_index),
        .active_filters  (active_filters),
        .busy            (busy),
        .done            (done)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_cycles     (perf_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {11'd0, wfc_start, ifc_start, cmp_start, busy, done,
                tile_index, wfc_address, active_filters};
    endfunction

    // Runs one layer, answering each sub-block start after 'lat' cycles.
    task automatic run_layer(input int nf, input int ws, input int ia, input int ts,
                             input int lat, input bit stray, input bit abort);
        int exp_tiles;
        int n_w, n_i, n_c, n_cd, n_done, done_cyc, zero_busy;
        int pw, pi, pc;
        int exp_act;
        bit busy_ok, stray_w, stray_s, aborted, done_in_reset;
        exp_tiles = (nf == 0 || ws == 0) ? 0 : (nf + AS - 1) / AS;
        n_w = 0; n_i = 0; n_c = 0; n_cd = 0; n_done = 0; done_cyc = -1; zero_busy = 0;
        pw = -1; pi = -1; pc = -1;
        busy_ok = 1'b1; stray_w = 1'b0; stray_s = 1'b0; aborted = 1'b0; done_in_reset = 1'b0;

        @(negedge clk);
        weight_size     = DW'(ws);
        number_filters  = DW'(nf);
        initial_address = AW'(ia);
        tile_stride     = AW'(ts);
        start           = 1'b1;
        @(negedge clk);
        // Later input changes must not affect the running layer
        weight_size     = DW'($urandom_range(1, 7));
        number_filters  = DW'($urandom_range(1, 60));
        initial_address = AW'($urandom_range(0, 32767));
        tile_stride     = AW'($urandom_range(0, 32767));

        for (int cyc = 0; cyc < 600 && n_done == 0 && !aborted; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start    = 1'b0;
            wfc_done = 1'b0;
            ifc_done = 1'b0;
            cmp_done = 1'b0;

            if (wfc_start) begin
                exp_act = nf - AS * n_w;
                if (exp_act > AS) exp_act = AS;
                check_eq("tile_index", tile_index, n_w);
                check_eq("wfc_address", wfc_address, (ia + n_w * ts) % (1 << AW));
                check_eq("active_filters", active_filters, exp_act);
                check_eq("busy_with_wfc", busy, 1);
                n_w++;
                pw = lat;
            end
            if (ifc_start) begin
                n_i++;
                check_eq("ifc_after_wfc", n_i, n_w);
                pi = lat;
            end
            if (cmp_start) begin
                n_c++;
                check_eq("cmp_after_ifc", n_c, n_i);
                pc = lat;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check_eq("busy_at_done", busy, 0);
                check_eq("cmp_done_before_done", n_cd, exp_tiles);
`ifdef SCHED_PERF_CNT_EN
                check_eq("perf_cycles", perf_cycles, done_cyc);
`endif
            end else if (n_w > 0 && busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
            if (exp_tiles == 0 && busy) zero_busy++;

            if (pw == 0) begin wfc_done = 1'b1; pw = -1; end else if (pw > 0) pw--;
            if (pi == 0) begin ifc_done = 1'b1; pi = -1; end else if (pi > 0) pi--;
            if (pc == 0) begin cmp_done = 1'b1; pc = -1; n_cd++; end else if (pc > 0) pc--;

            if (stray && !stray_w && pw == 1) begin
                cmp_done = 1'b1;
                stray_w  = 1'b1;
            end
            if (stray && !stray_s && pi == 1) begin
                start   = 1'b1;
                stray_s = 1'b1;
            end
            if (abort && n_c == 1 && pc == 1) begin
                #2 reset = 1'b0;
                #1 check_eq("outputs_on_abort", all_outputs(), 0);
                aborted = 1'b1;
            end
        end

        if (aborted) begin
            cmp_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (done) done_in_reset = 1'b1;
            end
            check_eq("no_done_after_abort", done_in_reset, 0);
            check_eq("outputs_held_in_reset", all_outputs(), 0);
            reset = 1'b1;
        end else begin
            check_eq("wfc_pulses", n_w, exp_tiles);
            check_eq("ifc_pulses", n_i, exp_tiles);
            check_eq("cmp_pulses", n_c, exp_tiles);
            check_eq("done_pulses", n_done, 1);
            check_eq("busy_through_layer", busy_ok, 1);
            if (exp_tiles == 0) begin
                check_eq("empty_done_latency", (done_cyc >= 0 && done_cyc <= 1), 1);
                check_eq("empty_busy_cycles", (zero_busy <= 1), 1);
            end
            @(negedge clk);
            wfc_done = 1'b0;
            ifc_done = 1'b0;
            cmp_done = 1'b0;
            check_eq("idle_after_done", {busy, done}, 0);
`ifdef SCHED_PERF_CNT_EN
            check_eq("perf_held", perf_cycles, done_cyc);
`endif
        end
    endtask

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        weight_size     = '0;
        number_filters  = '0;
        initial_address = '0;
        tile_stride     = '0;
        wfc_done        = 1'b0;
        ifc_done        = 1'b0;
        cmp_done        = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_outputs", all_outputs(), 0);
`ifdef SCHED_PERF_CNT_EN
        check_eq("reset_perf", perf_cycles, 0);
`endif
        reset = 1'b1;

        run_layer(9, 3, 0, 81, 4, 1'b0, 1'b0);
        run_layer(20, 3, 5, 100, 4, 1'b0, 1'b0);
        run_layer(0, 3, 12, 7, 4, 1'b0, 1'b0);
        run_layer(18, 3, 32'h7FF0, 32'h20, 4, 1'b0, 1'b0);
        run_layer(20, 3, 300, 50, 4, 1'b1, 1'b0);
        run_layer(20, 3, 40, 60, 4, 1'b0, 1'b1);
        run_layer(11, 2, 9, 1000, 3, 1'b0, 1'b0);
        run_layer(5, 0, 1, 1, 3, 1'b0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            run_layer($urandom_range(1, 40), $urandom_range(0, 4),
                      $urandom_range(0, 32767), $urandom_range(0, 32767),
                      $urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
